// File: rtl/product_accumulator_if.sv
// Handshake bundle: product vector plus bias in from the product stage, saturated sums out
// to the activation stage.
interface product_accumulator_if #(
    parameter int unsigned PRODUCTS_W = 1296,
    parameter int unsigned BIAS_W     = 48,
    parameter int unsigned SUM_W      = 72
);
    logic [PRODUCTS_W-1:0] products_in;
    logic                  products_valid;
    logic                  products_ready;
    logic [BIAS_W-1:0]     bias;
    logic [SUM_W-1:0]      sum_out;
    logic                  sum_valid;
    logic                  sum_ready;

    modport master (
        output products_in, products_valid, bias, sum_ready,
        input  products_ready, sum_out, sum_valid
    );

    modport slave (
        input  products_in, products_valid, bias, sum_ready,
        output products_ready, sum_out, sum_valid
    );
endinterface

// File: rtl/product_accumulator.sv
// Sequential per-filter tap summation, LANES taps per cycle, seeded with the filter bias;
// each filter's total is saturated to SUM_WIDTH and held until the consumer takes it.
module product_accumulator #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned HEIGHT        = 3,
    parameter int unsigned DEPTH         = 3,
    parameter int unsigned NUM_FILTER    = 3,
    parameter int unsigned PRODUCT_WIDTH = 16,
    parameter int unsigned BIAS_WIDTH    = 16,
    parameter int unsigned SUM_WIDTH     = 24,
    parameter int unsigned LANES         = 3
) (
    input logic                  clk,
    input logic                  rst,
    product_accumulator_if.slave bus
);
    localparam int unsigned N      = WIDTH * HEIGHT * DEPTH;
    localparam int unsigned IN_W   = (PRODUCT_WIDTH > BIAS_WIDTH) ? PRODUCT_WIDTH : BIAS_WIDTH;
    localparam int unsigned ACC_W  = IN_W + $clog2(N + 1) + 1;
    localparam int unsigned EXT_W  = (ACC_W > SUM_WIDTH) ? ACC_W : SUM_WIDTH;
    localparam int unsigned IDX_W  = $clog2(N + 1);
    localparam int unsigned VEC_W  = PRODUCT_WIDTH * N * NUM_FILTER;
    localparam int unsigned STEP_W = PRODUCT_WIDTH * LANES;
    localparam int unsigned OUT_W  = SUM_WIDTH * NUM_FILTER;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N - LANES);
    localparam logic [IDX_W-1:0]        IDX_STEP = IDX_W'(LANES);
    localparam logic signed [EXT_W-1:0] SAT_MAX  = EXT_W'((64'sd1 <<< (SUM_WIDTH - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [VEC_W-1:0]         prod_q, prod_d;
    logic signed [ACC_W-1:0]  acc_q [NUM_FILTER];
    logic signed [ACC_W-1:0]  acc_d [NUM_FILTER];
    logic signed [ACC_W-1:0]  lane_sum [NUM_FILTER];
    logic [OUT_W-1:0]         sum_q, sum_d;
    logic                     sum_valid_q, sum_valid_d;

    function automatic logic [SUM_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [EXT_W-1:0] x;
        x = EXT_W'(a);
        if (x > SAT_MAX) begin
            return SAT_MAX[SUM_WIDTH-1:0];
        end
        if (x < SAT_MIN) begin
            return SAT_MIN[SUM_WIDTH-1:0];
        end
        return x[SUM_WIDTH-1:0];
    endfunction

    assign bus.products_ready = (state_q == IDLE) && !rst;
    assign bus.sum_out        = sum_q;
    assign bus.sum_valid      = sum_valid_q;

    // The product register shifts down one lane group per cycle, so the current taps of
    // filter n always sit at the bottom of that filter's slot.
    always_comb begin
        for (int n = 0; n < NUM_FILTER; n++) begin
            lane_sum[n] = '0;
            for (int l = 0; l < LANES; l++) begin
                lane_sum[n] = lane_sum[n]
                    + ACC_W'($signed(prod_q[(n * N + l) * PRODUCT_WIDTH +: PRODUCT_WIDTH]));
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;

        case (state_q)
            IDLE: begin
                sum_valid_d = 1'b0;
                if (bus.products_valid && bus.products_ready) begin
                    prod_d = bus.products_in;
                    for (int n = 0; n < NUM_FILTER; n++) begin
                        acc_d[n] = ACC_W'($signed(bus.bias[n * BIAS_WIDTH +: BIAS_WIDTH]));
                    end
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                for (int n = 0; n < NUM_FILTER; n++) begin
                    acc_d[n] = acc_q[n] + lane_sum[n];
                end
                prod_d = prod_q >> STEP_W;
                idx_d  = idx_q + IDX_STEP;
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    sum_valid_d = 1'b1;
                    for (int n = 0; n < NUM_FILTER; n++) begin
                        sum_d[n * SUM_WIDTH +: SUM_WIDTH] = saturate(acc_d[n]);
                    end
                end
            end
            DONE: begin
                if (bus.sum_ready) begin
                    state_d     = IDLE;
                    sum_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            for (int n = 0; n < NUM_FILTER; n++) begin
                acc_q[n] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            acc_q       <= acc_d;
        end
    end

    // Tap data is only meaningful after an accept, so it carries no reset.
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default instance plus a SUM_WIDTH=16 instance
// for saturation; expected sums queued at drive time and compared when sum_valid rises.
module tb_product_accumulator;
    localparam int unsigned N    = 27;
    localparam int unsigned NF   = 3;
    localparam int unsigned PW   = 16;
    localparam int unsigned BW   = 16;
    localparam int unsigned SW   = 24;
    localparam int unsigned SWB  = 16;
    localparam int unsigned K    = 9;
    localparam int unsigned PV_W = PW * N * NF;
    localparam int unsigned BV_W = BW * NF;
    localparam int          TMO  = 40;

    typedef struct packed {
        logic signed [31:0] s2;
        logic signed [31:0] s1;
        logic signed [31:0] s0;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    product_accumulator_if #(.PRODUCTS_W(PV_W), .BIAS_W(BV_W), .SUM_W(SW * NF))  bus_a ();
    product_accumulator_if #(.PRODUCTS_W(PV_W), .BIAS_W(BV_W), .SUM_W(SWB * NF)) bus_b ();

    product_accumulator dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    product_accumulator #(.SUM_WIDTH(SWB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] model(input logic [PV_W-1:0] p, input logic [BV_W-1:0] b,
                                                 input int n, input int sw);
        longint s;
        longint lim;
        s = longint'($signed(b[n * BW +: BW]));
        for (int t = 0; t < N; t++) begin
            s += longint'($signed(p[(n * N + t) * PW +: PW]));
        end
        lim = longint'(1) <<< (sw - 1);
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
        return 32'(s);
    endfunction

    function automatic logic [PV_W-1:0] fill(input int v0, input int v1, input int v2, input bit alt2);
        logic [PV_W-1:0] p;
        p = '0;
        for (int t = 0; t < N; t++) begin
            p[t * PW +: PW]           = PW'(v0);
            p[(N + t) * PW +: PW]     = PW'(v1);
            p[(2 * N + t) * PW +: PW] = PW'((alt2 && (t % 2 == 1)) ? -v2 : v2);
        end
        return p;
    endfunction

    function automatic logic [PV_W-1:0] rand_vec();
        logic [PV_W-1:0] p;
        p = '0;
        for (int t = 0; t < N * NF; t++) begin
            p[t * PW +: PW] = PW'($urandom);
        end
        return p;
    endfunction

    function automatic logic [BV_W-1:0] bias3(input int b0, input int b1, input int b2);
        return {BW'(b2), BW'(b1), BW'(b0)};
    endfunction

    function automatic logic signed [31:0] out_a(input int n);
        return 32'($signed(bus_a.sum_out[n * SW +: SW]));
    endfunction

    function automatic logic signed [31:0] out_b(input int n);
        return 32'($signed(bus_b.sum_out[n * SWB +: SWB]));
    endfunction

    task automatic push_model(input logic [PV_W-1:0] p, input logic [BV_W-1:0] b);
        exp_t e;
        e.s0 = model(p, b, 0, SW);
        e.s1 = model(p, b, 1, SW);
        e.s2 = model(p, b, 2, SW);
        sb.push_back(e);
    endtask

    task automatic push_const(input int a, input int b, input int c);
        exp_t e;
        e.s0 = a;
        e.s1 = b;
        e.s2 = c;
        sb.push_back(e);
    endtask

    task automatic send_a(input logic [PV_W-1:0] p, input logic [BV_W-1:0] b, output int acc_cyc);
        int w;
        w = 0;
        bus_a.products_in    = p;
        bus_a.bias           = b;
        bus_a.products_valid = 1'b1;
        while (bus_a.products_ready !== 1'b1 && w < TMO) begin
            tick();
            w++;
        end
        chk("accept_ready", 32'(bus_a.products_ready), 1);
        tick();
        acc_cyc              = cyc;
        bus_a.products_valid = 1'b0;
        bus_a.products_in    = ~p;
        bus_a.bias           = ~b;
    endtask

    task automatic recv_a(input string tag, input int acc_cyc, input int hold);
        int   w;
        exp_t e;
        w = 0;
        while (bus_a.sum_valid !== 1'b1 && w < TMO) begin
            tick();
            w++;
        end
        chk({tag, "_valid"}, 32'(bus_a.sum_valid), 1);
        chk({tag, "_latency"}, cyc - acc_cyc, K);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, "_f0"}, out_a(0), e.s0);
        chk({tag, "_f1"}, out_a(1), e.s1);
        chk({tag, "_f2"}, out_a(2), e.s2);
        for (int h = 0; h < hold; h++) begin
            bus_a.products_valid = h[0];
            bus_a.products_in    = rand_vec();
            tick();
            chk({tag, "_hold_valid"}, 32'(bus_a.sum_valid), 1);
            chk({tag, "_hold_ready"}, 32'(bus_a.products_ready), 0);
            chk({tag, "_hold_f0"}, out_a(0), e.s0);
            chk({tag, "_hold_f2"}, out_a(2), e.s2);
        end
        bus_a.products_valid = 1'b0;
        bus_a.sum_ready      = 1'b1;
        tick();
        bus_a.sum_ready = 1'b0;
        chk({tag, "_valid_fall"}, 32'(bus_a.sum_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PV_W-1:0] pv;
        logic [BV_W-1:0] bv;
        int              acc;
        int              w;
        int              seen;
        int              val;
        int              acc6[3];
        exp_t            e;

        rst                  = 1'b1;
        bus_a.products_in    = '0;
        bus_a.bias           = '0;
        bus_a.products_valid = 1'b0;
        bus_a.sum_ready      = 1'b0;
        bus_b.products_in    = '0;
        bus_b.bias           = '0;
        bus_b.products_valid = 1'b0;
        bus_b.sum_ready      = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_ready_a", 32'(bus_a.products_ready), 0);
        chk("rst_ready_b", 32'(bus_b.products_ready), 0);
        chk("rst_valid", 32'(bus_a.sum_valid), 0);
        chk("rst_sum0", out_a(0), 0);
        chk("rst_sum2", out_a(2), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus_a.products_ready), 1);
        tick();

        // All ones, zero bias
        push_const(27, 27, 27);
        send_a(fill(1, 1, 1, 0), bias3(0, 0, 0), acc);
        recv_a("t1", acc, 0);

        // Mixed filters; sum_ready raised early has no effect
        push_const(2650, -27, 8);
        send_a(fill(100, -1, 5, 1), bias3(-50, 0, 3), acc);
        bus_a.sum_ready = 1'b1;
        recv_a("t2", acc, 0);

        // Saturation on the 16-bit output instance
        for (int v = 0; v < 2; v++) begin
            val = (v == 0) ? 32767 : -32768;
            bus_b.products_in    = fill(val, val, val, 0);
            bus_b.bias           = bias3(val, val, val);
            bus_b.products_valid = 1'b1;
            w = 0;
            while (bus_b.products_ready !== 1'b1 && w < TMO) begin
                tick();
                w++;
            end
            chk("t3_accept", 32'(bus_b.products_ready), 1);
            tick();
            bus_b.products_valid = 1'b0;
            w = 0;
            while (bus_b.sum_valid !== 1'b1 && w < TMO) begin
                tick();
                w++;
            end
            chk("t3_valid", 32'(bus_b.sum_valid), 1);
            chk("t3_f0", out_b(0), (v == 0) ? 32767 : -32768);
            chk("t3_f1", out_b(1), (v == 0) ? 32767 : -32768);
            chk("t3_f2", out_b(2), (v == 0) ? 32767 : -32768);
            bus_b.sum_ready = 1'b1;
            tick();
            bus_b.sum_ready = 1'b0;
        end

        // Backpressure in DONE with input noise, then an unaffected follow-up
        pv = fill(3, -4, 10, 0);
        bv = bias3(1, 2, -3);
        push_model(pv, bv);
        send_a(pv, bv, acc);
        recv_a("t4", acc, 5);
        pv = fill(-2, 6, 1, 1);
        bv = bias3(0, -7, 1000);
        push_model(pv, bv);
        send_a(pv, bv, acc);
        recv_a("t4b", acc, 0);

        // Reset in the 4th ACCUM cycle discards the transaction
        send_a(fill(7, 7, 7, 0), bias3(0, 0, 0), acc);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("t5_ready_in_rst", 32'(bus_a.products_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_ready_after", 32'(bus_a.products_ready), 1);
        chk("t5_valid_after", 32'(bus_a.sum_valid), 0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus_a.sum_valid !== 1'b0) seen++;
        end
        chk("t5_no_valid", seen, 0);
        push_const(54, 54, 54);
        send_a(fill(2, 2, 2, 0), bias3(0, 0, 0), acc);
        recv_a("t5", acc, 0);

        // Back-to-back with valid and sum_ready held high
        bus_a.sum_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            pv = rand_vec();
            bv = BV_W'({$urandom, $urandom});
            bus_a.products_in    = pv;
            bus_a.bias           = bv;
            bus_a.products_valid = 1'b1;
            push_model(pv, bv);
            w = 0;
            while (bus_a.products_ready !== 1'b1 && w < TMO) begin
                tick();
                w++;
            end
            chk("t6_accept", 32'(bus_a.products_ready), 1);
            tick();
            acc6[v] = cyc;
            if (v == 2) bus_a.products_valid = 1'b0;
            if (v > 0) chk("t6_spacing", acc6[v] - acc6[v-1], K + 2);
            w = 0;
            while (bus_a.sum_valid !== 1'b1 && w < TMO) begin
                tick();
                w++;
            end
            chk("t6_valid", 32'(bus_a.sum_valid), 1);
            chk("t6_latency", cyc - acc6[v], K);
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            chk("t6_f0", out_a(0), e.s0);
            chk("t6_f1", out_a(1), e.s1);
            chk("t6_f2", out_a(2), e.s2);
        end
        tick();
        bus_a.sum_ready = 1'b0;
        chk("t6_valid_fall", 32'(bus_a.sum_valid), 0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
